// File: rtl/room_temp_model.sv
// Room thermal plant model driven by the air-conditioning controller demands.
// Ports: clk, rst (async high) / enable, heating, cooling in / temp[4:0], step, fault, fault_seen out.
module room_temp_model #(
  parameter int TEMP_INIT    = 18,
  parameter int TEMP_AMBIENT = 25,
  parameter int TEMP_MIN     = 5,
  parameter int TEMP_MAX     = 31,
  parameter int HEAT_PERIOD  = 4,
  parameter int COOL_PERIOD  = 4,
  parameter int DRIFT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heating,
  input  logic       cooling,
  output logic [4:0] temp,
  output logic       step,
  output logic       fault,
  output logic       fault_seen
);

  // Mode codes equal the raw {heating,cooling} pattern.
  localparam logic [1:0] DRIFT = 2'b00;
  localparam logic [1:0] COOL  = 2'b01;
  localparam logic [1:0] HEAT  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  localparam int MAXHC = (HEAT_PERIOD > COOL_PERIOD) ?
                         HEAT_PERIOD : COOL_PERIOD;
  localparam int MAXP  = (MAXHC > DRIFT_PERIOD) ?
                         MAXHC : DRIFT_PERIOD;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [4:0] T_INIT = 5'(TEMP_INIT);
  localparam logic [4:0] T_AMB  = 5'(TEMP_AMBIENT);
  localparam logic [4:0] T_MIN  = 5'(TEMP_MIN);
  localparam logic [4:0] T_MAX  = 5'(TEMP_MAX);

  logic [1:0]    mode_q;
  logic [1:0]    decode;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period_m1;
  logic [4:0]    temp_next;
  logic          both;

  assign decode = {heating, cooling};
  assign both   = heating & cooling;

  always_comb begin
    period_m1 = '0;
    unique case (mode_q)
      HEAT:    period_m1 = CW'(HEAT_PERIOD - 1);
      COOL:    period_m1 = CW'(COOL_PERIOD - 1);
      DRIFT:   period_m1 = CW'(DRIFT_PERIOD - 1);
      default: period_m1 = '0;
    endcase
  end

  // Bounds are compared before the add/subtract so nothing wraps.
  always_comb begin
    temp_next = temp;
    unique case (mode_q)
      HEAT: begin
        if (temp < T_MAX) temp_next = temp + 5'd1;
      end
      COOL: begin
        if (temp > T_MIN) temp_next = temp - 5'd1;
      end
      DRIFT: begin
        if (temp < T_AMB)      temp_next = temp + 5'd1;
        else if (temp > T_AMB) temp_next = temp - 5'd1;
      end
      default: temp_next = temp;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp       <= T_INIT;
      mode_q     <= DRIFT;
      cnt        <= '0;
      step       <= 1'b0;
      fault      <= 1'b0;
      fault_seen <= 1'b0;
    end else begin
      fault      <= both;
      fault_seen <= fault_seen | both;
      step       <= 1'b0;
      if (enable) begin
        if (decode != mode_q) begin
          // A new demand always restarts the prescaler.
          mode_q <= decode;
          cnt    <= '0;
        end else if (mode_q == FAULT) begin
          cnt <= '0;
        end else if (cnt == period_m1) begin
          cnt  <= '0;
          temp <= temp_next;
          step <= (temp_next != temp);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
